nq_multiplier_axi4s_requester: RTL and testbench

Initiator side of the two-beat AXI4-S fixed-point multiplier protocol. Accepts one operand pair plus transaction ID from local logic and serializes it as two AXI4-S beats: multiplicand with tlast=0, then multiplier with tlast=1. It then waits for the single result beat (product in tdata, overflow in tuser) and returns product and status to the local client. One transaction is in flight at a time. Sits between DSP-consuming datapaths (filters, oscillators) and a shared multiplier responder.

---
 rtl/nq_multiplier_axi4s_requester.sv | 175 +++++++++++++++++
 tb/tb_nq_multiplier_axi4s_requester.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nq_multiplier_axi4s_requester.sv
// Initiator for the two-beat AXI4-S fixed-point multiplier: sends multiplicand then
// multiplier as one packet, waits for the single result beat and reports it locally.
module nq_multiplier_axi4s_requester #(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ID_WIDTH_P   = 4,
  parameter int N_BITS_P         = 32,
  parameter int TIMEOUT_P        = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [N_BITS_P-1:0]         req_multiplicand,
  input  logic [N_BITS_P-1:0]         req_multiplier,
  input  logic [AXI_ID_WIDTH_P-1:0]   req_id,
  output logic                        mul_tvalid,
  input  logic                        mul_tready,
  output logic [AXI_DATA_WIDTH_P-1:0] mul_tdata,
  output logic                        mul_tlast,
  output logic [AXI_ID_WIDTH_P-1:0]   mul_tid,
  input  logic                        res_tvalid,
  input  logic [AXI_DATA_WIDTH_P-1:0] res_tdata,
  input  logic                        res_tlast,
  input  logic [AXI_ID_WIDTH_P-1:0]   res_tid,
  input  logic                        res_tuser,
  output logic                        rsp_valid,
  output logic [N_BITS_P-1:0]         rsp_product,
  output logic                        rsp_overflow,
  output logic                        rsp_error,
  output logic                        rsp_timeout
);

  if (AXI_DATA_WIDTH_P < N_BITS_P) begin : g_width_chk
    $error("AXI_DATA_WIDTH_P must be >= N_BITS_P");
  end

  // Counter only has to reach TIMEOUT_P-1.
  localparam int CNT_W = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_P > 0) ? TIMEOUT_P - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, SEND_A, SEND_B, WAIT_RES, RESPOND
  } state_t;

  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic [N_BITS_P-1:0]         mplier_q, mplier_nxt;
  logic [AXI_ID_WIDTH_P-1:0]   id_q, id_nxt;

  logic                        req_ready_nxt;
  logic                        mul_tvalid_nxt, mul_tlast_nxt;
  logic [AXI_DATA_WIDTH_P-1:0] mul_tdata_nxt;
  logic [AXI_ID_WIDTH_P-1:0]   mul_tid_nxt;
  logic                        rsp_valid_nxt, rsp_overflow_nxt, rsp_error_nxt, rsp_timeout_nxt;
  logic [N_BITS_P-1:0]         rsp_product_nxt;

  // Upper result bits beyond the operand width carry no information.
  logic unused_res;
  assign unused_res = ^res_tdata;

  function automatic logic [AXI_DATA_WIDTH_P-1:0] sext(input logic [N_BITS_P-1:0] v);
    return AXI_DATA_WIDTH_P'($signed(v));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mplier_q     <= '0;
      id_q         <= '0;
      req_ready    <= 1'b1;
      mul_tvalid   <= 1'b0;
      mul_tdata    <= '0;
      mul_tlast    <= 1'b0;
      mul_tid      <= '0;
      rsp_valid    <= 1'b0;
      rsp_product  <= '0;
      rsp_overflow <= 1'b0;
      rsp_error    <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      mplier_q     <= mplier_nxt;
      id_q         <= id_nxt;
      req_ready    <= req_ready_nxt;
      mul_tvalid   <= mul_tvalid_nxt;
      mul_tdata    <= mul_tdata_nxt;
      mul_tlast    <= mul_tlast_nxt;
      mul_tid      <= mul_tid_nxt;
      rsp_valid    <= rsp_valid_nxt;
      rsp_product  <= rsp_product_nxt;
      rsp_overflow <= rsp_overflow_nxt;
      rsp_error    <= rsp_error_nxt;
      rsp_timeout  <= rsp_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    mplier_nxt       = mplier_q;
    id_nxt           = id_q;
    req_ready_nxt    = req_ready;
    mul_tvalid_nxt   = mul_tvalid;
    mul_tdata_nxt    = mul_tdata;
    mul_tlast_nxt    = mul_tlast;
    mul_tid_nxt      = mul_tid;
    rsp_valid_nxt    = 1'b0;
    rsp_product_nxt  = rsp_product;
    rsp_overflow_nxt = rsp_overflow;
    rsp_error_nxt    = rsp_error;
    rsp_timeout_nxt  = rsp_timeout;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_nxt  = 1'b0;
          mplier_nxt     = req_multiplier;
          id_nxt         = req_id;
          mul_tvalid_nxt = 1'b1;
          mul_tdata_nxt  = sext(req_multiplicand);
          mul_tlast_nxt  = 1'b0;
          mul_tid_nxt    = req_id;
          state_nxt      = SEND_A;
        end
      end
      SEND_A: begin
        // Second beat follows with no gap; tid already holds the stored ID.
        if (mul_tready) begin
          mul_tdata_nxt = sext(mplier_q);
          mul_tlast_nxt = 1'b1;
          state_nxt     = SEND_B;
        end
      end
      SEND_B: begin
        if (mul_tready) begin
          mul_tvalid_nxt = 1'b0;
          mul_tlast_nxt  = 1'b0;
          cnt_nxt        = '0;
          state_nxt      = WAIT_RES;
        end
      end
      WAIT_RES: begin
        cnt_nxt = cnt + CNT_W'(1);
        // A result on the timeout cycle takes priority over the abort.
        if (res_tvalid) begin
          rsp_valid_nxt    = 1'b1;
          rsp_product_nxt  = res_tdata[N_BITS_P-1:0];
          rsp_overflow_nxt = res_tuser;
          rsp_error_nxt    = (res_tid != id_q) || !res_tlast;
          rsp_timeout_nxt  = 1'b0;
          state_nxt        = RESPOND;
        end else if ((TIMEOUT_P != 0) && (cnt == CNT_LAST)) begin
          rsp_valid_nxt    = 1'b1;
          rsp_product_nxt  = '0;
          rsp_overflow_nxt = 1'b0;
          rsp_error_nxt    = 1'b0;
          rsp_timeout_nxt  = 1'b1;
          state_nxt        = RESPOND;
        end
      end
      RESPOND: begin
        req_ready_nxt = 1'b1;
        state_nxt     = IDLE;
      end
      default: begin
        req_ready_nxt  = 1'b1;
        mul_tvalid_nxt = 1'b0;
        state_nxt      = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nq_multiplier_axi4s_requester.sv
// Scoreboard bench: driver pushes expected beats/responses, negedge monitor pops and compares.
module tb_nq_multiplier_axi4s_requester;
  localparam int AW = 32, IW = 4, NB = 16, TO = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [NB-1:0] req_multiplicand = '0, req_multiplier = '0;
  logic [IW-1:0] req_id = '0;
  logic mul_tvalid, mul_tready = 1'b0, mul_tlast;
  logic [AW-1:0] mul_tdata;
  logic [IW-1:0] mul_tid;
  logic res_tvalid = 1'b0, res_tlast = 1'b0, res_tuser = 1'b0;
  logic [AW-1:0] res_tdata = '0;
  logic [IW-1:0] res_tid = '0;
  logic rsp_valid, rsp_overflow, rsp_error, rsp_timeout;
  logic [NB-1:0] rsp_product;

  always #5 clk = ~clk;

  nq_multiplier_axi4s_requester #(
    .AXI_DATA_WIDTH_P(AW), .AXI_ID_WIDTH_P(IW), .N_BITS_P(NB), .TIMEOUT_P(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier), .req_id(req_id),
    .mul_tvalid(mul_tvalid), .mul_tready(mul_tready), .mul_tdata(mul_tdata),
    .mul_tlast(mul_tlast), .mul_tid(mul_tid),
    .res_tvalid(res_tvalid), .res_tdata(res_tdata), .res_tlast(res_tlast),
    .res_tid(res_tid), .res_tuser(res_tuser),
    .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_overflow(rsp_overflow),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
  );

  typedef struct packed { logic [AW-1:0] data; logic last; logic [IW-1:0] id; } beat_t;
  typedef struct packed { logic [NB-1:0] product; logic ovf; logic err; logic to; } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  int    n_chk = 0, n_err = 0;
  int    cyc = 0, last_hs_edge = 0;
  logic  want_rst_chk = 1'b0, done = 1'b0, mon_done = 1'b0;
  logic  prev_rsp = 1'b0, held_v = 1'b0;
  beat_t held;

  always @(posedge clk) cyc <= cyc + 1;

  // Two's-complement widening done numerically rather than by bit replication.
  function automatic logic [AW-1:0] model_sext(input logic [NB-1:0] v);
    longint s;
    s = longint'(v);
    if (s >= (longint'(1) << (NB - 1))) s = s - (longint'(1) << NB);
    return AW'(s);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: all comparisons live here.
  always @(negedge clk) begin
    beat_t b;
    rsp_t  r;
    if (rst) begin
      held_v   = 1'b0;
      prev_rsp = 1'b0;
    end else begin
      if (want_rst_chk)
        check("reset_vals", {req_ready, mul_tvalid, mul_tdata, mul_tlast, mul_tid, rsp_valid,
                             rsp_product, rsp_overflow, rsp_error, rsp_timeout}, {1'b1, 58'd0});
      if (prev_rsp) begin
        check("rsp_one_cycle", 64'(rsp_valid), 64'(0));
        check("req_ready_rearm", 64'(req_ready), 64'(1));
      end
      if (held_v && mul_tvalid) check("beat_stable", {mul_tdata, mul_tlast, mul_tid}, held);
      held_v = mul_tvalid && !mul_tready;
      held   = {mul_tdata, mul_tlast, mul_tid};
      if (mul_tvalid && mul_tready) begin
        if (beat_q.size() == 0) check("beat_unexpected", 64'(1), 64'(0));
        else begin
          b = beat_q.pop_front();
          check("beat", {mul_tdata, mul_tlast, mul_tid}, b);
          if (mul_tlast) last_hs_edge = cyc + 1;
        end
      end
      if (rsp_valid) begin
        check("req_ready_busy", 64'(req_ready), 64'(0));
        if (rsp_q.size() == 0) check("rsp_unexpected", 64'(1), 64'(0));
        else begin
          r = rsp_q.pop_front();
          check("rsp", {rsp_product, rsp_overflow, rsp_error, rsp_timeout}, r);
          if (r.to) check("timeout_latency", 64'(cyc - last_hs_edge), 64'(TO));
        end
      end
      prev_rsp = rsp_valid;
      if (done && !mon_done) begin
        check("beat_q_empty", 64'(beat_q.size()), 64'(0));
        check("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        mon_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bound_fail(input string what);
    $display("FAIL %s: bound expired waiting for DUT (cycle %0d)", what, cyc);
    $fatal(1, "stopping run");
  endtask

  task automatic wait_hs(input string what);
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mul_tvalid && mul_tready) break;
    end
    if (i == 50) bound_fail(what);
    tick();
  endtask

  task automatic wait_rsp();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    if (i == 50) bound_fail("rsp_wait");
    req_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    req_valid  = 1'b0;
    res_tvalid = 1'b0;
    beat_q.delete();
    rsp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    want_rst_chk = 1'b1;
    @(negedge clk);
    #1 want_rst_chk = 1'b0;
  endtask

  task automatic send_result(input logic [AW-1:0] d, input logic u, input logic [IW-1:0] t,
                             input logic l);
    res_tvalid = 1'b1; res_tdata = d; res_tuser = u; res_tid = t; res_tlast = l;
    tick();
    res_tvalid = 1'b0; res_tdata = AW'($urandom); res_tid = IW'($urandom);
  endtask

  // mode: 0 result returned, 3 no result (timeout), 4 reset in WAIT_RES, 5 reset in SEND_B stall
  task automatic run_txn(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [IW-1:0] id,
                         input int stall_a, input int stall_b, input int lat, input int mode,
                         input logic [AW-1:0] rdata, input logic ruser,
                         input logic [IW-1:0] rtid, input logic rlast);
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (i == 50) bound_fail("req_ready_wait");
    beat_q.push_back({model_sext(a), 1'b0, id});
    beat_q.push_back({model_sext(b), 1'b1, id});
    req_valid = 1'b1; req_multiplicand = a; req_multiplier = b; req_id = id;
    mul_tready = (stall_a == 0);
    tick();
    // Junk requests while busy must be ignored.
    req_multiplicand = NB'($urandom); req_multiplier = NB'($urandom); req_id = IW'($urandom);
    repeat (stall_a) tick();
    mul_tready = 1'b1;
    wait_hs("beat1");
    mul_tready = (stall_b == 0);
    if (mode == 5) begin
      tick(); tick();
      do_reset();
      mul_tready = 1'b1;
      repeat (3) tick();
      return;
    end
    repeat (stall_b) tick();
    mul_tready = 1'b1;
    wait_hs("beat2");
    if (mode == 4) begin
      tick(); tick();
      do_reset();
      send_result(rdata, ruser, id, 1'b1);
      repeat (4) tick();
    end else if (mode == 3) begin
      rsp_q.push_back({NB'(0), 1'b0, 1'b0, 1'b1});
      wait_rsp();
      send_result(rdata, ruser, id, 1'b1);
      repeat (3) tick();
    end else begin
      repeat (lat) tick();
      rsp_q.push_back({NB'(rdata), ruser, (rtid != id) || !rlast, 1'b0});
      send_result(rdata, ruser, rtid, rlast);
      wait_rsp();
    end
  endtask

  initial begin
    logic [IW-1:0] id;
    logic [IW-1:0] rt;
    logic rl;
    int m;
    repeat (3) tick();
    rst = 1'b0;
    want_rst_chk = 1'b1;
    @(negedge clk);
    #1 want_rst_chk = 1'b0;

    // Basic Q8.8: 2.0 x 3.0 = 6.0
    run_txn(16'h0200, 16'h0300, 4'd5, 0, 0, 2, 0, 32'h0000_0600, 1'b0, 4'd5, 1'b1);
    // Sign extension and upper result bits discarded, overflow reported
    run_txn(16'h8000, 16'h7FFF, 4'd2, 0, 0, 1, 0, 32'hABCD_1234, 1'b1, 4'd2, 1'b1);
    // Backpressure on both beats
    run_txn(16'hFFFE, 16'h1234, 4'd9, 3, 3, 0, 0, 32'h1111_F00D, 1'b0, 4'd9, 1'b1);
    // ID mismatch, then missing tlast
    run_txn(16'h0101, 16'h0202, 4'd3, 0, 0, 3, 0, 32'h0000_4242, 1'b0, 4'd7, 1'b1);
    run_txn(16'h0303, 16'h0404, 4'd6, 1, 0, 0, 0, 32'h0000_5151, 1'b1, 4'd6, 1'b0);
    // Result on the timeout cycle wins
    run_txn(16'h0010, 16'h0020, 4'd1, 0, 0, TO - 1, 0, 32'h0000_0200, 1'b0, 4'd1, 1'b1);
    // Timeout, late result ignored, then normal completion
    run_txn(16'h0A0A, 16'h0B0B, 4'd4, 0, 2, 0, 3, 32'h0000_7777, 1'b0, 4'd4, 1'b1);
    run_txn(16'h0100, 16'hFF00, 4'd4, 0, 0, 4, 0, 32'hFFFF_FF00, 1'b0, 4'd4, 1'b1);
    // Reset in WAIT_RES and during a SEND_B stall, each followed by a normal transaction
    run_txn(16'h1111, 16'h2222, 4'd8, 0, 0, 0, 4, 32'h0000_3333, 1'b0, 4'd8, 1'b1);
    run_txn(16'h0200, 16'h0200, 4'd8, 0, 0, 1, 0, 32'h0000_0400, 1'b0, 4'd8, 1'b1);
    run_txn(16'h4444, 16'h5555, 4'd12, 1, 5, 0, 5, 32'h0, 1'b0, 4'd12, 1'b1);
    run_txn(16'h8001, 16'h7001, 4'd12, 0, 1, 2, 0, 32'h0000_9999, 1'b1, 4'd12, 1'b1);

    for (int k = 0; k < 24; k++) begin
      id = IW'($urandom);
      m  = $urandom_range(0, 9);
      rt = (m == 7) ? id ^ IW'($urandom_range(1, 15)) : id;
      rl = (m == 8) ? 1'b0 : 1'b1;
      run_txn(NB'($urandom), NB'($urandom), id, $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, TO - 1), (m == 9) ? 3 : 0, AW'($urandom), 1'($urandom), rt, rl);
    end

    repeat (3) tick();
    done = 1'b1;
    for (int i = 0; i < 20 && !mon_done; i++) tick();
    if (!mon_done) bound_fail("monitor_done");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
